// File: rtl/siso_xfer_ctrl_pkg.sv
// Shared types and sizing helpers for the SISO transfer controller.
// Holds the FSM state encoding and the counter width function.
package siso_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   // The counter must reach width+depth-1; the result is never narrower than one bit.
   function automatic int cnt_w(input int width, input int depth);
      return (width + depth > 1) ? $clog2(width + depth) : 1;
   endfunction

endpackage

// File: rtl/siso_xfer_ctrl_if.sv
// Parallel handshake and chain-side signals of the SISO transfer controller.
// The master is the parallel requester, the slave is the controller, and the chain is the SISO datapath.
interface siso_xfer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dout;
   logic             match;
   logic             siso_rst;
   logic             siso_si;
   logic             siso_so;

   modport master (
      output start, din,
      input  busy, done, dout, match
   );

   modport slave (
      input  start, din, siso_so,
      output busy, done, dout, match, siso_rst, siso_si
   );

   modport chain (
      input  siso_rst, siso_si,
      output siso_so
   );
endinterface

// File: rtl/siso_xfer_ctrl_sisoc.sv
// sisoc: a DEPTH-stage serial-in/serial-out shift chain with a synchronous active-high clear.
// It is the datapath that siso_xfer_ctrl sequences.
module sisoc #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic si,
   output logic so
);
   logic [DEPTH-1:0] stage_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= 1'b0;
               else     stage_reg[gi] <= si;
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= 1'b0;
               else     stage_reg[gi] <= stage_reg[gi-1];
            end
         end
      end
   endgenerate

   assign so = stage_reg[DEPTH-1];
endmodule

// File: rtl/siso_xfer_ctrl.sv
// SISO transfer controller: clears an external shift chain, then shifts a word through it MSB-first
// and reassembles the returning bits into dout, flagging whether the word came back intact.
module siso_xfer_ctrl
   import siso_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   siso_xfer_ctrl_if.slave  bus
);
   localparam int CW = cnt_w(WIDTH, DEPTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH + DEPTH - 1);
   localparam logic [CW-1:0] CNT_RX_BEG = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_TX_END = CW'(WIDTH);

   state_e           state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] tx_word_reg;
   logic [WIDTH-1:0] tx_sr_reg;
   logic [WIDTH-1:0] rx_reg;
   logic [WIDTH-1:0] dout_reg;
   logic             match_reg;
   logic             siso_rst_reg;
   logic             accept;
   logic             rx_en;
   logic [WIDTH-1:0] rx_next;

   assign accept  = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
   assign rx_en   = (state_reg == SHIFT) && (cnt_reg >= CNT_RX_BEG);
   assign rx_next = {rx_reg[WIDTH-2:0], bus.siso_so};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = CLEAR;
         CLEAR:   state_next = SHIFT;
         SHIFT:   if (cnt_reg == CNT_LAST) state_next = DONE;
         DONE:    state_next = accept ? CLEAR : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         tx_word_reg  <= '0;
         tx_sr_reg    <= '0;
         rx_reg       <= '0;
         dout_reg     <= '0;
         match_reg    <= 1'b0;
         siso_rst_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         // Registered so the chain clear lines up exactly with the CLEAR cycle.
         siso_rst_reg <= (state_next == CLEAR);
         cnt_reg      <= ((state_reg == SHIFT) && (cnt_reg != CNT_LAST)) ? cnt_reg + 1'b1 : '0;

         if (accept) begin
            tx_word_reg <= bus.din;
            tx_sr_reg   <= bus.din;
            rx_reg      <= '0;
         end else if (state_reg == SHIFT) begin
            tx_sr_reg <= tx_sr_reg << 1;
            if (rx_en) rx_reg <= rx_next;
         end

         // The final sample arrives on the same edge that enters DONE.
         if ((state_reg == SHIFT) && (cnt_reg == CNT_LAST)) begin
            dout_reg  <= rx_next;
            match_reg <= (rx_next == tx_word_reg);
         end
      end
   end

   assign bus.busy     = (state_reg == CLEAR) || (state_reg == SHIFT);
   assign bus.done     = (state_reg == DONE);
   assign bus.dout     = dout_reg;
   assign bus.match    = match_reg;
   assign bus.siso_rst = siso_rst_reg;
   assign bus.siso_si  = ((state_reg == SHIFT) && (cnt_reg < CNT_TX_END)) ? tx_sr_reg[WIDTH-1] : 1'b0;
endmodule

// File: tb/tb_siso_xfer_ctrl.sv
// Loopback bench for siso_xfer_ctrl driving a sisoc chain; expected words go through a scoreboard queue.
`timescale 1ns/1ps
module tb_siso_xfer_ctrl;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic fault;
   logic chain_so;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [WIDTH-1:0] exp_dout_q[$];
   logic             exp_match_q[$];

   siso_xfer_ctrl_if #(.WIDTH(WIDTH)) bus();

   siso_xfer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sisoc #(.DEPTH(DEPTH)) u_chain (
      .clk (clk),
      .rst (bus.siso_rst),
      .si  (bus.siso_si),
      .so  (chain_so)
   );

   assign bus.siso_so = fault ? 1'b0 : chain_so;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word with start for one edge; the bench is in CLEAR (cycle 1) on return.
   task automatic launch(input logic [WIDTH-1:0] w, input bit keep_start, input bit expect_result);
      logic [WIDTH-1:0] e;
      bus.din   = w;
      bus.start = 1'b1;
      if (expect_result) begin
         e = fault ? '0 : w;
         exp_dout_q.push_back(e);
         exp_match_q.push_back(e == w);
      end
      tick();
      if (!keep_start) bus.start = 1'b0;
   endtask

   // Count edges until done is seen; -1 when the budget runs out.
   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (bus.done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags busy=%b done=%b required busy=0 done=0", bus.busy, bus.done);
      end
      n_tests++;
      if (bus.dout !== 4'h0 || bus.match !== 1'b0) begin
         n_fail++; $display("FAIL reset_dout dout=%h match=%b required dout=0 match=0", bus.dout, bus.match);
      end
      n_tests++;
      if (bus.siso_rst !== 1'b1 || bus.siso_si !== 1'b0) begin
         n_fail++; $display("FAIL reset_chain siso_rst=%b siso_si=%b required 1/0", bus.siso_rst, bus.siso_si);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (bus.siso_rst !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release siso_rst=%b busy=%b required 0/0", bus.siso_rst, bus.busy);
      end
      $display("[TB] reset: busy=%b done=%b dout=%h siso_rst=%b", bus.busy, bus.done, bus.dout, bus.siso_rst);
   endtask

   task automatic test_loopback();
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] ed;
      logic             em;
      logic             exp_si;
      w = 4'b1011;
      launch(w, 1'b0, 1'b1);
      n_tests++;
      if (bus.busy !== 1'b1 || bus.siso_rst !== 1'b1 || bus.siso_si !== 1'b0) begin
         n_fail++; $display("FAIL loop_clear busy=%b siso_rst=%b siso_si=%b required 1/1/0", bus.busy, bus.siso_rst, bus.siso_si);
      end
      for (int k = 0; k < WIDTH + DEPTH; k++) begin
         tick();
         exp_si = (k < WIDTH) ? w[WIDTH-1-k] : 1'b0;
         n_tests++;
         if (bus.siso_si !== exp_si || bus.siso_rst !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL loop_si[%0d] siso_si=%b siso_rst=%b done=%b required si=%b rst=0 done=0", k, bus.siso_si, bus.siso_rst, bus.done, exp_si);
         end
      end
      tick();
      n_tests++;
      if (bus.done !== 1'b1) begin
         n_fail++; $display("FAIL loop_done_cycle done=%b required 1 in cycle 10", bus.done);
      end
      n_tests++;
      if (exp_dout_q.size() == 0) begin
         n_fail++; $display("FAIL loop_scoreboard queue empty required one entry");
      end else begin
         ed = exp_dout_q.pop_front();
         em = exp_match_q.pop_front();
         if (bus.dout !== ed || bus.match !== em) begin
            n_fail++; $display("FAIL loop_result dout=%h match=%b required dout=%h match=%b", bus.dout, bus.match, ed, em);
         end
      end
      $display("[TB] loopback: din=%h dout=%h match=%b", w, bus.dout, bus.match);
      tick();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL loop_idle busy=%b done=%b required 0/0", bus.busy, bus.done);
      end
   endtask

   task automatic test_back_to_back();
      int               cyc;
      logic [WIDTH-1:0] ed;
      logic             em;
      launch(4'h3, 1'b1, 1'b1);
      wait_done(cyc);
      n_tests++;
      if (cyc != WIDTH + DEPTH + 1) begin
         n_fail++; $display("FAIL b2b_first_latency cycles=%0d required %0d", cyc, WIDTH + DEPTH + 1);
      end
      n_tests++;
      if (exp_dout_q.size() == 0) begin
         n_fail++; $display("FAIL b2b_first_scoreboard queue empty required one entry");
      end else begin
         ed = exp_dout_q.pop_front();
         em = exp_match_q.pop_front();
         if (bus.dout !== ed || bus.match !== em) begin
            n_fail++; $display("FAIL b2b_first dout=%h match=%b required dout=%h match=%b", bus.dout, bus.match, ed, em);
         end
      end
      $display("[TB] back_to_back #1: dout=%h match=%b", bus.dout, bus.match);
      launch(4'hC, 1'b0, 1'b1);
      n_tests++;
      if (bus.busy !== 1'b1 || bus.siso_rst !== 1'b1) begin
         n_fail++; $display("FAIL b2b_no_idle busy=%b siso_rst=%b required 1/1", bus.busy, bus.siso_rst);
      end
      wait_done(cyc);
      n_tests++;
      if (cyc != WIDTH + DEPTH + 1) begin
         n_fail++; $display("FAIL b2b_spacing cycles=%0d required %0d", cyc + 1, WIDTH + DEPTH + 2);
      end
      n_tests++;
      if (exp_dout_q.size() == 0) begin
         n_fail++; $display("FAIL b2b_second_scoreboard queue empty required one entry");
      end else begin
         ed = exp_dout_q.pop_front();
         em = exp_match_q.pop_front();
         if (bus.dout !== ed || bus.match !== em) begin
            n_fail++; $display("FAIL b2b_second dout=%h match=%b required dout=%h match=%b", bus.dout, bus.match, ed, em);
         end
      end
      $display("[TB] back_to_back #2: dout=%h match=%b", bus.dout, bus.match);
      tick();
   endtask

   task automatic test_ignored_start();
      int               cyc;
      logic [WIDTH-1:0] ed;
      logic             em;
      launch(4'hA, 1'b0, 1'b1);
      tick();
      tick();
      bus.din   = 4'hF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.din   = 4'h0;
      wait_done(cyc);
      n_tests++;
      if (cyc != WIDTH + DEPTH - 2) begin
         n_fail++; $display("FAIL ignore_latency cycles=%0d required %0d", cyc, WIDTH + DEPTH - 2);
      end
      n_tests++;
      if (exp_dout_q.size() == 0) begin
         n_fail++; $display("FAIL ignore_scoreboard queue empty required one entry");
      end else begin
         ed = exp_dout_q.pop_front();
         em = exp_match_q.pop_front();
         if (bus.dout !== ed || bus.match !== em) begin
            n_fail++; $display("FAIL ignore_result dout=%h match=%b required dout=%h match=%b", bus.dout, bus.match, ed, em);
         end
      end
      $display("[TB] ignored_start: dout=%h match=%b", bus.dout, bus.match);
      tick();
   endtask

   task automatic test_fault();
      int               cyc;
      logic [WIDTH-1:0] ed;
      logic             em;
      fault = 1'b1;
      launch(4'h5, 1'b0, 1'b1);
      wait_done(cyc);
      n_tests++;
      if (exp_dout_q.size() == 0 || cyc < 0) begin
         n_fail++; $display("FAIL fault_done cycles=%0d queue=%0d required done and one entry", cyc, exp_dout_q.size());
      end else begin
         ed = exp_dout_q.pop_front();
         em = exp_match_q.pop_front();
         if (bus.dout !== ed || bus.match !== em) begin
            n_fail++; $display("FAIL fault_result dout=%h match=%b required dout=%h match=%b", bus.dout, bus.match, ed, em);
         end
      end
      $display("[TB] fault: dout=%h match=%b", bus.dout, bus.match);
      fault = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      int               cyc;
      logic [WIDTH-1:0] ed;
      logic             em;
      bit               saw_done;
      launch(4'h6, 1'b0, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.siso_rst !== 1'b1 || bus.dout !== 4'h0) begin
         n_fail++; $display("FAIL midrst_abort busy=%b done=%b siso_rst=%b dout=%h required 0/0/1/0", bus.busy, bus.done, bus.siso_rst, bus.dout);
      end
      saw_done = 1'b0;
      for (int i = 0; i < WIDTH + DEPTH + 2; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      n_tests++;
      if (saw_done) begin
         n_fail++; $display("FAIL midrst_quiet activity=%b required 0 after abort", saw_done);
      end
      launch(4'h9, 1'b0, 1'b1);
      wait_done(cyc);
      n_tests++;
      if (exp_dout_q.size() == 0 || cyc != WIDTH + DEPTH + 1) begin
         n_fail++; $display("FAIL midrst_retry cycles=%0d queue=%0d required %0d and one entry", cyc, exp_dout_q.size(), WIDTH + DEPTH + 1);
      end else begin
         ed = exp_dout_q.pop_front();
         em = exp_match_q.pop_front();
         if (bus.dout !== ed || bus.match !== em) begin
            n_fail++; $display("FAIL midrst_result dout=%h match=%b required dout=%h match=%b", bus.dout, bus.match, ed, em);
         end
      end
      $display("[TB] mid_reset retry: dout=%h match=%b", bus.dout, bus.match);
      tick();
   endtask

   initial begin
      rst       = 1'b0;
      fault     = 1'b0;
      bus.start = 1'b0;
      bus.din   = '0;
      test_reset();
      test_loopback();
      test_back_to_back();
      test_ignored_start();
      test_fault();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
